// File: rtl/glitch_sched.sv
// glitch_sched: campaign scheduler for a clock-glitch injector.
// Waits for a target trigger edge, counts target clock edges, fires the
// injector for a fixed window, holds off, then sweeps the delay and repeats.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no campaign running, waiting for arm
// ARMED   | waiting for a fresh synced ext_trig rising edge
// DELAY   | counting synced target clock rising edges up to cur_delay
// FIRE    | glitch_trig high for max(fire_len,1) clk cycles
// HOLDOFF | settle time before next attempt or end of campaign
module glitch_sched #(
    parameter int DELAY_W = 16,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clean_target_clock,
    input  logic               ext_trig,
    input  logic               arm,
    input  logic               abort,
    input  logic [DELAY_W-1:0] cfg_delay_start,
    input  logic [DELAY_W-1:0] cfg_delay_step,
    input  logic [CNT_W-1:0]   cfg_attempts,
    input  logic [LEN_W-1:0]   cfg_fire_len,
    input  logic [LEN_W-1:0]   cfg_holdoff,
    output logic               glitch_trig,
    output logic               busy,
    output logic               attempt_done,
    output logic               campaign_done,
    output logic [DELAY_W-1:0] cur_delay,
    output logic [CNT_W-1:0]   attempt_idx
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_DELAY   = 3'd2;
    localparam logic [2:0] S_FIRE    = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic [2:0]         state;
    logic [2:0]         trig_sr;
    logic [2:0]         tgt_sr;
    logic               trig_rise;
    logic               tgt_rise;

    logic [DELAY_W-1:0] lat_step;
    logic [CNT_W-1:0]   lat_attempts;
    logic [LEN_W-1:0]   lat_fire_len;
    logic [LEN_W-1:0]   lat_holdoff;

    logic [DELAY_W-1:0] dly_cnt;
    logic [DELAY_W:0]   dly_inc;
    logic [LEN_W-1:0]   tmr;

    logic [LEN_W-1:0]   fire_load;
    logic [LEN_W-1:0]   hold_load;
    logic [CNT_W-1:0]   attempts_eff;
    logic               last_attempt;
    logic [DELAY_W:0]   delay_sum;
    logic [DELAY_W-1:0] delay_next;

    // Two-flop synchronizers plus one history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_sr <= '0;
            tgt_sr  <= '0;
        end else begin
            trig_sr <= {trig_sr[1:0], ext_trig};
            tgt_sr  <= {tgt_sr[1:0], clean_target_clock};
        end
    end

    assign trig_rise = trig_sr[1] & ~trig_sr[2];
    assign tgt_rise  = tgt_sr[1] & ~tgt_sr[2];

    // Zero-length settings collapse to one cycle, so timers load length-1
    always_comb begin
        fire_load    = (lat_fire_len == '0) ? '0 : lat_fire_len - 1'b1;
        hold_load    = (lat_holdoff == '0) ? '0 : lat_holdoff - 1'b1;
        attempts_eff = (lat_attempts == '0) ? CNT_W'(1) : lat_attempts;
        last_attempt = ({1'b0, attempt_idx} + 1'b1) >= {1'b0, attempts_eff};
        dly_inc      = {1'b0, dly_cnt} + 1'b1;
        delay_sum    = {1'b0, cur_delay} + {1'b0, lat_step};
        delay_next   = delay_sum[DELAY_W] ? '1 : delay_sum[DELAY_W-1:0];
    end

    assign busy = (state != S_IDLE);

    // Campaign sequencer: state, counters, latched config and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            lat_step      <= '0;
            lat_attempts  <= '0;
            lat_fire_len  <= '0;
            lat_holdoff   <= '0;
            dly_cnt       <= '0;
            tmr           <= '0;
            glitch_trig   <= 1'b0;
            attempt_done  <= 1'b0;
            campaign_done <= 1'b0;
            cur_delay     <= '0;
            attempt_idx   <= '0;
        end else begin
            attempt_done  <= 1'b0;
            campaign_done <= 1'b0;
            if (state != S_IDLE && abort) begin
                state       <= S_IDLE;
                glitch_trig <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (arm && !abort) begin
                            lat_step     <= cfg_delay_step;
                            lat_attempts <= cfg_attempts;
                            lat_fire_len <= cfg_fire_len;
                            lat_holdoff  <= cfg_holdoff;
                            cur_delay    <= cfg_delay_start;
                            attempt_idx  <= '0;
                            state        <= S_ARMED;
                        end
                    end
                    S_ARMED: begin
                        if (trig_rise) begin
                            dly_cnt <= '0;
                            state   <= S_DELAY;
                        end
                    end
                    S_DELAY: begin
                        // zero delay fires without waiting for a target edge
                        if (dly_cnt == cur_delay) begin
                            glitch_trig <= 1'b1;
                            tmr         <= fire_load;
                            state       <= S_FIRE;
                        end else if (tgt_rise) begin
                            if (dly_inc == {1'b0, cur_delay}) begin
                                glitch_trig <= 1'b1;
                                tmr         <= fire_load;
                                state       <= S_FIRE;
                            end else begin
                                dly_cnt <= dly_inc[DELAY_W-1:0];
                            end
                        end
                    end
                    S_FIRE: begin
                        if (tmr == '0) begin
                            glitch_trig <= 1'b0;
                            tmr         <= hold_load;
                            state       <= S_HOLDOFF;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    S_HOLDOFF: begin
                        if (tmr == '0) begin
                            attempt_done <= 1'b1;
                            if (last_attempt) begin
                                campaign_done <= 1'b1;
                                state         <= S_IDLE;
                            end else begin
                                attempt_idx <= attempt_idx + 1'b1;
                                cur_delay   <= delay_next;
                                state       <= S_ARMED;
                            end
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_glitch_sched.sv
// Directed testbench for glitch_sched with hand-computed expectations.
module tb_glitch_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clean_target_clock = 1'b0;
    logic        ext_trig = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_delay_start = '0;
    logic [15:0] cfg_delay_step = '0;
    logic [7:0]  cfg_attempts = '0;
    logic [15:0] cfg_fire_len = '0;
    logic [15:0] cfg_holdoff = '0;
    logic        glitch_trig, busy, attempt_done, campaign_done;
    logic [15:0] cur_delay;
    logic [7:0]  attempt_idx;

    // narrow-delay instance used to reach saturation in reasonable time
    logic        arm2 = 1'b0;
    logic        abort2 = 1'b0;
    logic [7:0]  s_start = '0;
    logic [7:0]  s_step = '0;
    logic        s_glitch, s_busy, s_ad, s_cd;
    logic [7:0]  s_dly;
    logic [7:0]  s_idx;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int tgt_cnt = 0;
    int last_tgt_cyc = 0;
    int raise_cyc = 0;
    int n_ad = 0;
    int n_cd = 0;
    int n_both = 0;
    int wcnt = 0;
    logic gl_prev = 1'b0;
    int fire_edge_q[$];
    int fire_tgt_lat_q[$];
    int fire_trig_lat_q[$];
    int idx_q[$];
    int dly_q[$];
    int width_q[$];

    glitch_sched dut (
        .clk(clk), .rst(rst), .clean_target_clock(clean_target_clock),
        .ext_trig(ext_trig), .arm(arm), .abort(abort),
        .cfg_delay_start(cfg_delay_start), .cfg_delay_step(cfg_delay_step),
        .cfg_attempts(cfg_attempts), .cfg_fire_len(cfg_fire_len),
        .cfg_holdoff(cfg_holdoff), .glitch_trig(glitch_trig), .busy(busy),
        .attempt_done(attempt_done), .campaign_done(campaign_done),
        .cur_delay(cur_delay), .attempt_idx(attempt_idx)
    );

    glitch_sched #(.DELAY_W(8)) dut_s (
        .clk(clk), .rst(rst), .clean_target_clock(clean_target_clock),
        .ext_trig(ext_trig), .arm(arm2), .abort(abort2),
        .cfg_delay_start(s_start), .cfg_delay_step(s_step),
        .cfg_attempts(8'd2), .cfg_fire_len(16'd1), .cfg_holdoff(16'd0),
        .glitch_trig(s_glitch), .busy(s_busy), .attempt_done(s_ad),
        .campaign_done(s_cd), .cur_delay(s_dly), .attempt_idx(s_idx)
    );

    always #5 clk = ~clk;

    // Observe the main instance on the falling edge and log each fire
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (glitch_trig && !gl_prev) begin
            fire_edge_q.push_back(tgt_cnt);
            fire_tgt_lat_q.push_back(cyc - last_tgt_cyc);
            fire_trig_lat_q.push_back(cyc - raise_cyc);
            idx_q.push_back(int'(attempt_idx));
            dly_q.push_back(int'(cur_delay));
            wcnt = 0;
        end
        if (glitch_trig) wcnt = wcnt + 1;
        if (!glitch_trig && gl_prev) width_q.push_back(wcnt);
        if (attempt_done) n_ad = n_ad + 1;
        if (campaign_done) n_cd = n_cd + 1;
        if (attempt_done && campaign_done) n_both = n_both + 1;
        gl_prev = glitch_trig;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_arm;
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic trig_rise;
        ext_trig = 1'b1;
        raise_cyc = cyc;
        tick(5);
        ext_trig = 1'b0;
    endtask

    task automatic tgt_edges(input int n);
        for (int i = 0; i < n; i++) begin
            clean_target_clock = 1'b1;
            tgt_cnt = tgt_cnt + 1;
            last_tgt_cyc = cyc;
            tick(4);
            clean_target_clock = 1'b0;
            tick(4);
        end
    endtask

    task automatic wait_glitch;
        int k;
        k = 0;
        while (!glitch_trig && k < 40) begin
            tick(1);
            k++;
        end
        chk("wait_glitch", 32'(glitch_trig), 32'd1);
    endtask

    task automatic set_cfg(input logic [15:0] st, input logic [15:0] sp,
                           input logic [7:0] at, input logic [15:0] fl,
                           input logic [15:0] ho);
        cfg_delay_start = st;
        cfg_delay_step  = sp;
        cfg_attempts    = at;
        cfg_fire_len    = fl;
        cfg_holdoff     = ho;
    endtask

    initial begin
        int b_f, b_w, b_ad, b_cd, b_both;
        int exp_d[4];
        exp_d = '{2, 5, 8, 11};

        tick(2);
        chk("rst_glitch", 32'(glitch_trig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'({attempt_done, campaign_done}), 32'd0);
        chk("rst_cur_delay", 32'(cur_delay), 32'd0);
        rst = 1'b1;
        tick(2);

        // single shot
        set_cfg(16'd5, 16'd0, 8'd1, 16'd3, 16'd2);
        b_f = fire_edge_q.size(); b_w = width_q.size();
        b_ad = n_ad; b_cd = n_cd; b_both = n_both;
        pulse_arm();
        chk("ss_busy_after_arm", 32'(busy), 32'd1);
        trig_rise();
        tgt_cnt = 0;
        tgt_edges(5);
        tick(10);
        chk("ss_fires", 32'(fire_edge_q.size() - b_f), 32'd1);
        chk("ss_fire_edge", 32'(fire_edge_q[b_f]), 32'd5);
        chk("ss_fire_lat", 32'(fire_tgt_lat_q[b_f]), 32'd4);
        chk("ss_width", 32'(width_q[b_w]), 32'd3);
        chk("ss_attempt_done", 32'(n_ad - b_ad), 32'd1);
        chk("ss_campaign_done", 32'(n_cd - b_cd), 32'd1);
        chk("ss_same_clk", 32'(n_both - b_both), 32'd1);
        chk("ss_busy_end", 32'(busy), 32'd0);

        // sweep, with cfg changes after arm that must not matter
        set_cfg(16'd2, 16'd3, 8'd4, 16'd2, 16'd0);
        b_f = fire_edge_q.size(); b_w = width_q.size();
        b_ad = n_ad; b_cd = n_cd;
        pulse_arm();
        cfg_delay_step = 16'd7;
        cfg_attempts = 8'd1;
        for (int a = 0; a < 4; a++) begin
            trig_rise();
            tgt_cnt = 0;
            tgt_edges(exp_d[a]);
            tick(10);
        end
        chk("sw_fires", 32'(fire_edge_q.size() - b_f), 32'd4);
        for (int a = 0; a < 4; a++) begin
            chk($sformatf("sw_edge%0d", a), 32'(fire_edge_q[b_f + a]), 32'(exp_d[a]));
            chk($sformatf("sw_idx%0d", a), 32'(idx_q[b_f + a]), 32'(a));
            chk($sformatf("sw_dly%0d", a), 32'(dly_q[b_f + a]), 32'(exp_d[a]));
            chk($sformatf("sw_width%0d", a), 32'(width_q[b_w + a]), 32'd2);
        end
        chk("sw_attempt_done", 32'(n_ad - b_ad), 32'd4);
        chk("sw_campaign_done", 32'(n_cd - b_cd), 32'd1);
        chk("sw_last_idx", 32'(attempt_idx), 32'd3);
        chk("sw_busy_end", 32'(busy), 32'd0);

        // zero / degenerate config
        set_cfg(16'd0, 16'd1, 8'd0, 16'd0, 16'd0);
        b_f = fire_edge_q.size(); b_w = width_q.size();
        b_ad = n_ad; b_cd = n_cd;
        tgt_cnt = 0;
        pulse_arm();
        trig_rise();
        tick(15);
        chk("z_fires", 32'(fire_edge_q.size() - b_f), 32'd1);
        chk("z_trig_lat", 32'(fire_trig_lat_q[b_f]), 32'd5);
        chk("z_width", 32'(width_q[b_w]), 32'd1);
        chk("z_attempt_done", 32'(n_ad - b_ad), 32'd1);
        chk("z_campaign_done", 32'(n_cd - b_cd), 32'd1);

        // trigger already high at arm
        set_cfg(16'd0, 16'd0, 8'd1, 16'd1, 16'd0);
        b_f = fire_edge_q.size();
        ext_trig = 1'b1;
        tick(5);
        pulse_arm();
        tick(10);
        chk("lvl_no_fire", 32'(fire_edge_q.size() - b_f), 32'd0);
        chk("lvl_busy", 32'(busy), 32'd1);
        ext_trig = 1'b0;
        tick(5);
        trig_rise();
        tick(15);
        chk("lvl_fire", 32'(fire_edge_q.size() - b_f), 32'd1);

        // abort during fire, arm ignored while busy
        set_cfg(16'd0, 16'd0, 8'd1, 16'd10, 16'd2);
        b_f = fire_edge_q.size(); b_w = width_q.size();
        b_ad = n_ad; b_cd = n_cd;
        pulse_arm();
        ext_trig = 1'b1;
        wait_glitch();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        chk("ab_arm_ignored", 32'(glitch_trig), 32'd1);
        tick(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("ab_glitch_low", 32'(glitch_trig), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);
        ext_trig = 1'b0;
        tick(20);
        chk("ab_width", 32'(width_q[b_w]), 32'd4);
        chk("ab_no_done", 32'((n_ad - b_ad) + (n_cd - b_cd)), 32'd0);
        chk("ab_fires", 32'(fire_edge_q.size() - b_f), 32'd1);
        abort = 1'b1;
        arm = 1'b1;
        tick(1);
        abort = 1'b0;
        arm = 1'b0;
        chk("ab_arm_same_clk", 32'(busy), 32'd0);

        // saturation on the 8-bit instance: 0xF0 + 0x20 -> 0xFF
        s_start = 8'hF0;
        s_step = 8'h20;
        arm2 = 1'b1;
        tick(1);
        arm2 = 1'b0;
        trig_rise();
        tgt_edges(240);
        tick(12);
        chk("sat_idx", 32'(s_idx), 32'd1);
        chk("sat_delay", 32'(s_dly), 32'hFF);
        chk("sat_busy", 32'(s_busy), 32'd1);
        abort2 = 1'b1;
        tick(1);
        abort2 = 1'b0;
        chk("sat_abort_busy", 32'(s_busy), 32'd0);
        chk("sat_abort_keep", 32'(s_dly), 32'hFF);

        // async reset during fire
        set_cfg(16'd0, 16'd0, 8'd1, 16'd10, 16'd0);
        pulse_arm();
        ext_trig = 1'b1;
        wait_glitch();
        ext_trig = 1'b0;
        rst = 1'b0;
        #1;
        chk("rstf_glitch", 32'(glitch_trig), 32'd0);
        chk("rstf_busy", 32'(busy), 32'd0);
        #2;
        rst = 1'b1;
        tick(3);

        // async reset during delay
        set_cfg(16'd5, 16'd0, 8'd3, 16'd2, 16'd0);
        pulse_arm();
        trig_rise();
        tgt_edges(2);
        chk("rstd_busy_before", 32'(busy), 32'd1);
        chk("rstd_cur_before", 32'(cur_delay), 32'd5);
        rst = 1'b0;
        #1;
        chk("rstd_busy", 32'(busy), 32'd0);
        chk("rstd_cur_delay", 32'(cur_delay), 32'd0);
        chk("rstd_outs", 32'({glitch_trig, attempt_done, campaign_done, attempt_idx}), 32'd0);
        #2;
        rst = 1'b1;
        tick(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
